wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
Shares the single register-file write port between two result sources: the ALU path (src 0) and the data-memory/load path (src 1). Each source uses a valid/ready handshake. The block picks one source per cycle with round-robin arbitration and registers the winner onto the write port (reg_write_out_wb, rd_out_wb, wb_data). It sits between the MEM stage outputs and the register file, in place of a fixed mem_to_reg select.

Parameters:
DATA_W, 32, width of write-back data
REG_AW, 5, register address width
CNT_W, 16, width of the committed-write counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU result offered
alu_rd  input  REG_AW  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU result accepted this cycle
dm_valid  input  1  load result offered
dm_rd  input  REG_AW  load destination register
dm_data  input  DATA_W  load data
dm_ready  output  1  load result accepted this cycle
reg_write_out_wb  output  1  register-file write enable
rd_out_wb  output  REG_AW  register-file write address
wb_data  output  DATA_W  register-file write data
wb_src  output  1  source of the current write (0 = ALU, 1 = DM)
wb_count  output  CNT_W  number of committed writes with rd != 0

Behaviour:
- Reset (reset == 0, asynchronous): reg_write_out_wb = 0, rd_out_wb = 0, wb_data = 0, wb_src = 0, wb_count = 0, last_grant = 1 (so ALU wins the first tie).
- Transfer rule: a source's transfer occurs when valid && ready are both high at a rising clk.
- Grant logic is combinational on valids and last_grant:
  - Only one source valid: that source is granted.
  - Both valid: the source != last_grant is granted.
  - Neither valid: no grant.
- Readiness: alu_ready = grant_alu and dm_ready = grant_dm. Ready never depends on the output port; the port accepts one write every cycle.
- Source obligation: a source holds valid, rd and data stable until ready. The arbiter does not check this.
- Latency is 1 cycle: the granted transfer at edge N appears on the write port during cycle N+1.
  - reg_write_out_wb = 1 if rd != 0, else 0.
  - rd_out_wb and wb_data take the granted source's values.
  - wb_src takes the grant index.
- Cycle with no grant: reg_write_out_wb = 0; rd_out_wb, wb_data and wb_src hold their previous values.
- Writes to x0: rd == 0 is accepted (ready = 1) but produces no write enable and does not increment wb_count.
- last_grant updates only on a cycle with a grant.
- wb_count increments by 1 per committed write with rd != 0 and wraps modulo 2^CNT_W without saturating.
- Same rd from both sources in one cycle: granted in round-robin order, one per cycle, with no merging. The later write wins in the register file.
- Reset asserted mid-stream: the in-flight write is dropped (enable forced low immediately) and no ready is asserted while reset == 0. On release, arbitration restarts with ALU priority.
- No X-propagation: the grant is defined for every valid combination.

Optional Feature:
Macro WB_PORT_ARBITER_TRACE_EN.
- Defined: on every cycle with reg_write_out_wb == 1, a simulation-only $display prints source, rd_out_wb and wb_data in hex.
- Not defined: no display statements are compiled. Port list and timing are identical in both builds.

Decomposition:
- Shared package wb_pkg holds:
  - localparams SRC_ALU = 1'b0 and SRC_DM = 1'b1
  - default widths DATA_W/REG_AW
  - typedef wb_req_t {valid, rd, data}
- Sub-module rr_arb2: a 2-requester round-robin arbiter with inputs req[1:0] and last_grant, outputs gnt[1:0] and gnt_idx. It is purely combinational; last_grant stays in the parent.

Test Plan:
- After reset release, alu_valid = 1 (rd = 5, data = 0x1234) and dm_valid = 0 → alu_ready = 1 that cycle; next cycle reg_write_out_wb = 1, rd_out_wb = 5, wb_data = 0x1234, wb_src = 0, wb_count = 1.
- Both sources valid for 4 cycles (ALU rd = 1, DM rd = 2, held until ready):
  - Grants alternate ALU, DM, ALU, DM.
  - Port shows rd 1, 2, 1, 2 on consecutive cycles.
  - Never two readies in one cycle.
- dm_valid with rd = 0, data = 0xDEAD → dm_ready = 1; next cycle reg_write_out_wb = 0 and wb_count is unchanged.
- Counter wrap: preset via CNT_W = 4, then 17 writes with nonzero rd → wb_count == 1.
- reset driven low between grant and output edge → reg_write_out_wb drops to 0 asynchronously, without waiting for clk. After release with both valid, ALU is granted first.
- Idle for 3 cycles after a write of data 0xBEEF → reg_write_out_wb = 0 while wb_data stays 0xBEEF.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back port arbiter: source indices,
// default widths and the source request record.
package wb_pkg;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_DM  = 1'b1;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 5;

    typedef struct packed {
        logic                 valid;
        logic [WB_REG_AW-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. This block is combinational only; the
// parent holds last_grant and advances it on every granted cycle.
module rr_arb2
    import wb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx = SRC_ALU;
        gnt     = 2'b00;
        case (req)
            2'b01:   gnt_idx = SRC_ALU;
            2'b10:   gnt_idx = SRC_DM;
            2'b11:   gnt_idx = ~last_grant;
            default: gnt_idx = SRC_ALU;
        endcase
        if (|req) gnt = (gnt_idx == SRC_DM) ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin share of the register-file write port between ALU and load
// results, with one cycle of latency. Define WB_PORT_ARBITER_TRACE_EN to get a write trace.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int REG_AW = WB_REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              dm_valid,
    input  logic [REG_AW-1:0] dm_rd,
    input  logic [DATA_W-1:0] dm_data,
    output logic              dm_ready,
    output logic              reg_write_out_wb,
    output logic [REG_AW-1:0] rd_out_wb,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_src,
    output logic [CNT_W-1:0]  wb_count
);

    logic [1:0]        req, gnt;
    logic              gnt_idx, any_gnt;
    logic [REG_AW-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    logic              wen_q,  wen_d;
    logic [REG_AW-1:0] rd_q,   rd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              src_q,  src_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    // Requests are masked while reset is low, so no ready can escape then.
    assign req = {dm_valid, alu_valid} & {2{reset}};

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_q),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    assign any_gnt   = |gnt;
    assign alu_ready = gnt[0];
    assign dm_ready  = gnt[1];
    assign sel_rd    = (gnt_idx == SRC_DM) ? dm_rd   : alu_rd;
    assign sel_data  = (gnt_idx == SRC_DM) ? dm_data : alu_data;

    always_comb begin
        wen_d  = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        src_d  = src_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (any_gnt) begin
            // x0 is accepted but never written or counted.
            wen_d  = (sel_rd != '0);
            rd_d   = sel_rd;
            data_d = sel_data;
            src_d  = gnt_idx;
            last_d = gnt_idx;
            if (sel_rd != '0) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            src_q  <= SRC_ALU;
            last_q <= SRC_DM;
            cnt_q  <= '0;
        end else begin
            wen_q  <= wen_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            src_q  <= src_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    assign reg_write_out_wb = wen_q;
    assign rd_out_wb        = rd_q;
    assign wb_data          = data_q;
    assign wb_src           = src_q;
    assign wb_count         = cnt_q;

`ifdef WB_PORT_ARBITER_TRACE_EN
    always @(posedge clk) begin
        if (reg_write_out_wb)
            $display("[wb] src=%0d rd=%h data=%h", wb_src, rd_out_wb, wb_data);
    end
`else
`endif

endmodule
